// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit for the MUL/DIV opcodes.
// Iterates one bit per cycle (shift-add multiply, restoring divide) and
// returns {Result2, Result} = {HI, LO} through a valid/ready response.
// Optional build macro MD_EARLY_OUT_EN: multiplies finish as soon as the
// remaining multiplier bits are all zero. Results are identical either way.

module md_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] X,
   input  logic [WIDTH-1:0] Y,
   input  logic [3:0]       AluOP,
   input  logic             kill,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [WIDTH-1:0] Result,
   output logic [WIDTH-1:0] Result2,
   output logic             div_zero,
   output logic             busy
);

   // Opcode encoding shared with the ALU
   localparam logic [3:0] OP_MULTU = 4'b0011;
   localparam logic [3:0] OP_MULT  = 4'b1101;
   localparam logic [3:0] OP_DIVU  = 4'b0100;
   localparam logic [3:0] OP_DIV   = 4'b1111;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   state_t state;
   state_t state_next;

   // Request decode
   logic op_mul;
   logic op_div;
   logic op_signed;
   logic op_valid;
   logic accept;
   logic [WIDTH-1:0] x_mag;
   logic [WIDTH-1:0] y_mag;

   // Latched operation context
   logic is_mul;
   logic is_zdiv;
   logic sign_x;
   logic sign_y;
   logic [CNT_W-1:0] cnt;

   // Multiply working registers: product accumulator, left-shifting
   // multiplicand and right-shifting multiplier
   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH-1:0] mcand;
   logic [WIDTH-1:0]   mplier;

   // Divide working registers: partial remainder, dividend/quotient shifter
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] divisor;

   // One-step next values and sign-corrected final values
   logic [2*WIDTH-1:0] prod_step;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH:0]     shifted;
   logic [WIDTH:0]     diff;
   logic [WIDTH-1:0]   quo_step;
   logic [WIDTH-1:0]   rem_step;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;
   logic [WIDTH-1:0]   x_orig;
   logic               early_done;
   logic               calc_last;

   // Registered response
   logic [WIDTH-1:0] result_q;
   logic [WIDTH-1:0] result2_q;
   logic             div_zero_q;

   assign Result   = result_q;
   assign Result2  = result2_q;
   assign div_zero = div_zero_q;

   // Decode the incoming opcode and form operand magnitudes for signed ops
   always_comb begin
      op_mul    = (AluOP == OP_MULTU) || (AluOP == OP_MULT);
      op_div    = (AluOP == OP_DIVU) || (AluOP == OP_DIV);
      op_signed = (AluOP == OP_MULT) || (AluOP == OP_DIV);
      op_valid  = op_mul || op_div;
      x_mag     = (op_signed && X[WIDTH-1]) ? -X : X;
      y_mag     = (op_signed && Y[WIDTH-1]) ? -Y : Y;
   end

   // Single iteration step for both datapaths plus final sign correction.
   // The restoring divide uses a WIDTH+1 bit trial subtraction; bit WIDTH
   // of the difference is the borrow that rejects the subtraction.
   always_comb begin
      prod_step = mplier[0] ? (prod + mcand) : prod;
      prod_fix  = (sign_x ^ sign_y) ? -prod_step : prod_step;

      shifted   = {rem, quo[WIDTH-1]};
      diff      = shifted - {1'b0, divisor};
      quo_step  = {quo[WIDTH-2:0], ~diff[WIDTH]};
      rem_step  = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
      quo_fix   = (sign_x ^ sign_y) ? -quo_step : quo_step;
      rem_fix   = sign_x ? -rem_step : rem_step;

      x_orig    = sign_x ? -quo : quo;
   end

   // Early finish for multiplies once no multiplier bits remain above the
   // one being consumed this cycle
`ifdef MD_EARLY_OUT_EN
   always_comb begin
      early_done = is_mul && (mplier[WIDTH-1:1] == '0);
   end
`else
   always_comb begin
      early_done = 1'b0;
   end
`endif

   // Divide-by-zero needs only one CALC edge; otherwise run WIDTH steps
   always_comb begin
      calc_last = is_zdiv || (cnt == LAST_CNT) || early_done;
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic and handshake outputs; kill overrides everything
   always_comb begin
      state_next = state;
      req_ready  = rst_n && (state == IDLE) && !kill;
      accept     = req_valid && req_ready;
      resp_valid = (state == DONE);
      busy       = (state != IDLE);

      case (state)
         IDLE: begin
            if (accept) begin
               state_next = op_valid ? CALC : DONE;
            end
         end
         CALC: begin
            if (calc_last) begin
               state_next = DONE;
            end
         end
         DONE: begin
            if (resp_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      if (kill) begin
         state_next = IDLE;
      end
   end

   // Datapath: latch operands on accept, iterate in CALC, and load the
   // response registers only on entry to DONE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         is_mul     <= 1'b0;
         is_zdiv    <= 1'b0;
         sign_x     <= 1'b0;
         sign_y     <= 1'b0;
         cnt        <= '0;
         prod       <= '0;
         mcand      <= '0;
         mplier     <= '0;
         rem        <= '0;
         quo        <= '0;
         divisor    <= '0;
         result_q   <= '0;
         result2_q  <= '0;
         div_zero_q <= 1'b0;
      end else if (accept) begin
         is_mul   <= op_mul;
         is_zdiv  <= op_div && (Y == '0);
         sign_x   <= op_signed && X[WIDTH-1];
         sign_y   <= op_signed && Y[WIDTH-1];
         cnt      <= '0;
         prod     <= '0;
         mcand    <= {{WIDTH{1'b0}}, x_mag};
         mplier   <= y_mag;
         rem      <= '0;
         quo      <= x_mag;
         divisor  <= y_mag;
         if (!op_valid) begin
            result_q   <= '0;
            result2_q  <= '0;
            div_zero_q <= 1'b0;
         end
      end else if ((state == CALC) && !kill) begin
         cnt    <= cnt + 1'b1;
         prod   <= prod_step;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         rem    <= rem_step;
         quo    <= quo_step;
         if (calc_last) begin
            if (is_zdiv) begin
               result_q   <= '1;
               result2_q  <= x_orig;
               div_zero_q <= 1'b1;
            end else if (is_mul) begin
               result_q   <= prod_fix[WIDTH-1:0];
               result2_q  <= prod_fix[2*WIDTH-1:WIDTH];
               div_zero_q <= 1'b0;
            end else begin
               result_q   <= quo_fix;
               result2_q  <= rem_fix;
               div_zero_q <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed vector bench for md_unit, plus hand-written
// sequences for back-pressure, kill and reset in the middle of an operation.
// Honours MD_EARLY_OUT_EN for the expected multiply latency.

module tb_md_unit;

   localparam logic [3:0] OP_MULTU = 4'b0011;
   localparam logic [3:0] OP_MULT  = 4'b1101;
   localparam logic [3:0] OP_DIVU  = 4'b0100;
   localparam logic [3:0] OP_DIV   = 4'b1111;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [31:0] X = '0;
   logic [31:0] Y = '0;
   logic [3:0]  AluOP = '0;
   logic        kill = 1'b0;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [31:0] Result;
   logic [31:0] Result2;
   logic        div_zero;
   logic        busy;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] x;
      logic [31:0] y;
      logic [31:0] lo;
      logic [31:0] hi;
      logic        dz;
   } vec_t;

   vec_t vecs[17];

   md_unit #(.WIDTH(32), .CNT_W(6)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .X          (X),
      .Y          (Y),
      .AluOP      (AluOP),
      .kill       (kill),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .Result     (Result),
      .Result2    (Result2),
      .div_zero   (div_zero),
      .busy       (busy)
   );

   // Free-running clock, 10 time units per period
   always #5 clk = ~clk;

   // Compare one value and count it
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, actual, expected);
      end
   endtask

   // Expected edges from accept to resp_valid; -1 means not checked
   function automatic int expLatency(input logic [3:0] op, input logic [31:0] y);
      if (op == OP_DIVU || op == OP_DIV) begin
         return (y == 32'd0) ? 1 : 32;
      end
      if (op == OP_MULTU || op == OP_MULT) begin
`ifdef MD_EARLY_OUT_EN
         begin
            logic [31:0] m;
            int idx;
            m = (op == OP_MULT && y[31]) ? -y : y;
            idx = 0;
            for (int i = 0; i < 32; i++) begin
               if (m[i]) idx = i;
            end
            return idx + 1;
         end
`else
         return 32;
`endif
      end
      return -1;
   endfunction

   // Present a request at the falling edge and let the next rising edge take it
   task automatic startOp(input string name, input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
      @(negedge clk);
      req_valid = 1'b1;
      AluOP = op;
      X = x;
      Y = y;
      checkOutput({name, " req_ready"}, 32'(req_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   // Count rising edges until resp_valid is seen at a falling edge (bounded)
   task automatic waitResp(output int n);
      n = 0;
      while (!resp_valid && n < 100) begin
         @(posedge clk);
         n++;
         @(negedge clk);
      end
   endtask

   // Run one full transaction from the vector table and check the response
   task automatic applyStimulus(input vec_t v, input int idx);
      string name;
      int n;
      int lat;
      name = $sformatf("vec%0d", idx);
      lat = expLatency(v.op, v.y);
      startOp(name, v.op, v.x, v.y);
      waitResp(n);
      checkOutput({name, " resp_valid"}, 32'(resp_valid), 32'd1);
      if (lat >= 0) checkOutput({name, " latency"}, n, lat);
      checkOutput({name, " Result"}, Result, v.lo);
      checkOutput({name, " Result2"}, Result2, v.hi);
      checkOutput({name, " div_zero"}, 32'(div_zero), 32'(v.dz));
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      checkOutput({name, " resp_valid after handshake"}, 32'(resp_valid), 32'd0);
      checkOutput({name, " req_ready after handshake"}, 32'(req_ready), 32'd1);
   endtask

   // Watch for a stray response over a number of cycles
   task automatic expectSilence(input string name, input int cycles);
      int seen;
      seen = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (resp_valid) seen++;
      end
      checkOutput({name, " stray resp_valid"}, seen, 0);
   endtask

   initial begin
      int n;

      vecs[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0};
      vecs[1]  = '{OP_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFEB, 32'hFFFFFFFF, 1'b0};
      vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0};
      vecs[3]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0};
      vecs[4]  = '{OP_DIVU,  32'd100,      32'd0,        32'hFFFFFFFF, 32'd100,      1'b1};
      vecs[5]  = '{OP_DIVU,  32'd1000,     32'd3,        32'd333,      32'd1,        1'b0};
      vecs[6]  = '{OP_MULTU, 32'd5,        32'd1,        32'd5,        32'd0,        1'b0};
      vecs[7]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h00000000, 32'h40000000, 1'b0};
      vecs[8]  = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        1'b0};
      vecs[9]  = '{OP_DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 1'b0};
      vecs[10] = '{OP_DIV,   32'd5,        32'd0,        32'hFFFFFFFF, 32'd5,        1'b1};
      vecs[11] = '{OP_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1};
      vecs[12] = '{OP_MULT,  32'h12345678, 32'd0,        32'd0,        32'd0,        1'b0};
      vecs[13] = '{OP_MULTU, 32'h00010000, 32'h00010000, 32'd0,        32'd1,        1'b0};
      vecs[14] = '{4'b0000,  32'h12345678, 32'h9ABCDEF0, 32'd0,        32'd0,        1'b0};
      vecs[15] = '{OP_DIVU,  32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'd0,        1'b0};
      vecs[16] = '{OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0};

      // Reset state while rst_n is held low
      #3;
      checkOutput("reset req_ready", 32'(req_ready), 32'd0);
      checkOutput("reset resp_valid", 32'(resp_valid), 32'd0);
      checkOutput("reset busy", 32'(busy), 32'd0);
      checkOutput("reset Result", Result, 32'd0);
      checkOutput("reset Result2", Result2, 32'd0);
      checkOutput("reset div_zero", 32'(div_zero), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("post-reset req_ready", 32'(req_ready), 32'd1);

      // Table-driven transactions
      for (int i = 0; i < 17; i++) begin
         applyStimulus(vecs[i], i);
      end

      // Back-pressure: response held for 5 cycles with resp_ready low
      startOp("hold", OP_DIV, 32'hFFFFFFF9, 32'd2);
      waitResp(n);
      for (int i = 0; i < 5; i++) begin
         checkOutput("hold resp_valid", 32'(resp_valid), 32'd1);
         checkOutput("hold Result", Result, 32'hFFFFFFFD);
         checkOutput("hold Result2", Result2, 32'hFFFFFFFF);
         checkOutput("hold req_ready", 32'(req_ready), 32'd0);
         @(negedge clk);
      end
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      checkOutput("hold release resp_valid", 32'(resp_valid), 32'd0);
      checkOutput("hold release req_ready", 32'(req_ready), 32'd1);

      // Kill at CALC count 10 together with a new request
      startOp("kill", OP_DIVU, 32'd1000, 32'd3);
      repeat (9) @(negedge clk);
      kill = 1'b1;
      req_valid = 1'b1;
      AluOP = OP_MULTU;
      X = 32'd2;
      Y = 32'd3;
      checkOutput("kill req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      kill = 1'b0;
      req_valid = 1'b0;
      checkOutput("kill busy", 32'(busy), 32'd0);
      checkOutput("kill resp_valid", 32'(resp_valid), 32'd0);
      @(negedge clk);
      checkOutput("kill not accepted", 32'(busy), 32'd0);
      expectSilence("kill", 40);

      // Kill in DONE with a simultaneous resp_ready drops the response
      startOp("kill done", OP_MULTU, 32'd3, 32'd4);
      waitResp(n);
      checkOutput("kill done resp_valid", 32'(resp_valid), 32'd1);
      checkOutput("kill done Result", Result, 32'd12);
      kill = 1'b1;
      resp_ready = 1'b1;
      @(negedge clk);
      kill = 1'b0;
      resp_ready = 1'b0;
      checkOutput("kill done dropped", 32'(resp_valid), 32'd0);
      checkOutput("kill done idle", 32'(busy), 32'd0);

      // Reset in the middle of CALC clears outputs at once
      startOp("midreset", OP_MULTU, 32'd7, 32'd9);
      repeat (5) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("midreset resp_valid", 32'(resp_valid), 32'd0);
      checkOutput("midreset busy", 32'(busy), 32'd0);
      checkOutput("midreset req_ready", 32'(req_ready), 32'd0);
      checkOutput("midreset Result", Result, 32'd0);
      checkOutput("midreset Result2", Result2, 32'd0);
      checkOutput("midreset div_zero", 32'(div_zero), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      expectSilence("midreset", 40);

      // Unit still works afterwards
      applyStimulus(vecs[5], 5);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
